// File: rtl/capture_arbiter_if.sv
// capture_arbiter_if: groups the requester/consumer side of capture_arbiter.
//
// Handshake: oValid rises when a capture completes and stays high, with
// oData/oSrc stable, until iAck is sampled high on a rising edge. That edge
// is the transfer; oValid drops after it. iAck while oValid is low is ignored.
//
// Signals:
//   iReq     [NUM_REQ]          per-requester level request
//   iData    [NUM_REQ*DATA_W]   requester i in bits [i*DATA_W +: DATA_W]
//   iAck                        consumer accepts oData
//   oGrant   [NUM_REQ]          one-hot grant
//   oSrc     [SRC_W]            granted / captured requester index
//   oData    [DATA_W]           captured data
//   oValid                      oData valid, held until acknowledged
//   oBusy                       arbiter not idle
//   oTimeout                    one-cycle ack-timeout pulse (CAPTURE_ACK_TIMEOUT_EN only)
//
// Modports: master = requesters/consumer side, slave = arbiter.
interface capture_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        iReq;
  logic [NUM_REQ*DATA_W-1:0] iData;
  logic                      iAck;
  logic [NUM_REQ-1:0]        oGrant;
  logic [SRC_W-1:0]          oSrc;
  logic [DATA_W-1:0]         oData;
  logic                      oValid;
  logic                      oBusy;
`ifdef CAPTURE_ACK_TIMEOUT_EN
  logic                      oTimeout;

  modport master (output iReq, iData, iAck,
                  input  oGrant, oSrc, oData, oValid, oBusy, oTimeout);
  modport slave  (input  iReq, iData, iAck,
                  output oGrant, oSrc, oData, oValid, oBusy, oTimeout);
`else
  modport master (output iReq, iData, iAck,
                  input  oGrant, oSrc, oData, oValid, oBusy);
  modport slave  (input  iReq, iData, iAck,
                  output oGrant, oSrc, oData, oValid, oBusy);
`endif
endinterface

// File: rtl/capture_arbiter.sv
// capture_arbiter: shares one DATA_W capture register among NUM_REQ
// requesters. Round-robin selection among edge-qualified requests, a
// HOLD_CYCLES settle window under grant, capture, then presentation to a
// consumer with a valid/ack handshake (see capture_arbiter_if).
//
// Ports:
//   iClock     system clock, rising edge
//   iReset     synchronous active-high reset
//   bus        capture_arbiter_if.slave (requests, data, ack, grant, outputs)
//   oDbgState  current FSM state (0=IDLE, 1=GRANT, 2=PRESENT)
//
// Optional feature: define CAPTURE_ACK_TIMEOUT_EN to abandon a presented
// word after ACK_TIMEOUT cycles without iAck and pulse bus.oTimeout.
module capture_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                    iClock,
  input  logic                    iReset,
  capture_arbiter_if.slave        bus,
  output logic [1:0]              oDbgState
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_CYCLES < 1 || HOLD_CYCLES > 15 ||
      ACK_TIMEOUT < 1) begin : g_param_check
    $error("capture_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  armed_q, armed_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [3:0]          hold_q, hold_d;

  logic [NUM_REQ-1:0]  elig;
  logic                sel_found;
  logic [SRC_W-1:0]    sel_idx;
  logic [SRC_W-1:0]    src_next;
  logic                done;
  int                  idx;

`ifdef CAPTURE_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                timeout_q, timeout_d;
`endif

  // Round-robin search: first eligible index at or above the pointer, wrapping.
  always_comb begin
    elig      = bus.iReq & armed_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!sel_found && elig[idx]) begin
        sel_found = 1'b1;
        sel_idx   = SRC_W'(idx);
      end
    end
    src_next = (int'(src_q) == NUM_REQ - 1) ? '0 : src_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    done    = 1'b0;
`ifdef CAPTURE_ACK_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = NUM_REQ'(1) << sel_idx;
          src_d   = sel_idx;
          hold_d  = 4'(HOLD_CYCLES - 1);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // A requester dropping its request mid-settle abandons the grant.
        if (!bus.iReq[src_q]) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (hold_q == 4'd0) begin
          data_d  = bus.iData[int'(src_q)*DATA_W +: DATA_W];
          valid_d = 1'b1;
          state_d = S_PRESENT;
`ifdef CAPTURE_ACK_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      S_PRESENT: begin
        if (bus.iAck) begin
          done = 1'b1;
`ifdef CAPTURE_ACK_TIMEOUT_EN
        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          done      = 1'b1;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
        if (done) begin
          valid_d = 1'b0;
          grant_d = '0;
          ptr_d   = src_next;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A low request always re-arms; it wins over the completion clear so a
    // request released during PRESENT is captured again when re-raised.
    armed_d = armed_q;
    if (done) armed_d[src_q] = 1'b0;
    armed_d = armed_d | ~bus.iReq;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      armed_q <= '1;
      src_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
`ifdef CAPTURE_ACK_TIMEOUT_EN
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      armed_q <= armed_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
`ifdef CAPTURE_ACK_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.oGrant = grant_q;
  assign bus.oSrc   = src_q;
  assign bus.oData  = data_q;
  assign bus.oValid = valid_q;
  assign bus.oBusy  = (state_q != S_IDLE);
`ifdef CAPTURE_ACK_TIMEOUT_EN
  assign bus.oTimeout = timeout_q;
`endif
  assign oDbgState  = state_q;

endmodule

// File: tb/tb_capture_arbiter.sv
// tb_capture_arbiter: self-checking bench for capture_arbiter (NUM_REQ=4,
// DATA_W=8, HOLD_CYCLES=2, ACK_TIMEOUT=64). Directed scenarios plus a
// randomized run scored against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_capture_arbiter;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int HOLD  = 2;
  localparam int ACKTO = 64;
  localparam int SW    = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  capture_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  capture_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(ACKTO)
  ) dut (
    .iClock(clk),
    .iReset(rst),
    .bus(bus),
    .oDbgState(dbg_state)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [SW+DW-1:0] exp_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.iReq = '0; bus.iAck = 1'b0; bus.iData = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_ack();
    bus.iAck = 1'b1;
    @(negedge clk);
    bus.iAck = 1'b0;
  endtask

  // Bounded wait for oValid, sampled on falling edges; cyc = edges waited.
  task automatic wait_valid(input int max_cyc, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < max_cyc && !ok) begin
      @(negedge clk);
      cyc++;
      if (bus.oValid) ok = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_total++;
    if ({bus.oGrant, bus.oSrc, bus.oData, bus.oValid, bus.oBusy, dbg_state} !== '0)
      $display("FAIL reset_idle: got grant=%b src=%0d data=%h valid=%b busy=%b state=%0d want all 0",
               bus.oGrant, bus.oSrc, bus.oData, bus.oValid, bus.oBusy, dbg_state);
    else n_pass++;
    // Run into PRESENT, then reset mid-operation.
    bus.iReq = 4'b1111; bus.iData = 32'h44332211;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({bus.oGrant, bus.oSrc, bus.oData, bus.oValid, bus.oBusy} !== '0)
      $display("FAIL reset_abort: got grant=%b src=%0d data=%h valid=%b busy=%b want all 0",
               bus.oGrant, bus.oSrc, bus.oData, bus.oValid, bus.oBusy);
    else n_pass++;
`ifdef CAPTURE_ACK_TIMEOUT_EN
    n_total++;
    if (bus.oTimeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.oTimeout);
    else n_pass++;
`endif
    // Reset re-arms everyone and zeroes the pointer: held requests grant 0.
    @(negedge clk);
    n_total++;
    if (bus.oGrant !== 4'b0001) $display("FAIL reset_rearm: got grant=%b want 0001", bus.oGrant);
    else n_pass++;
    bus.iReq = '0;
  endtask

  task automatic test_single_capture();
    do_reset();
    bus.iData = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.iReq  = 4'b0100;
    @(negedge clk);
    n_total++;
    if ({bus.oGrant, bus.oBusy, bus.oValid} !== {4'b0100, 1'b1, 1'b0})
      $display("FAIL single_grant: got grant=%b busy=%b valid=%b want 0100 1 0",
               bus.oGrant, bus.oBusy, bus.oValid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.oValid !== 1'b0) $display("FAIL single_settle: got valid=%b want 0", bus.oValid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({bus.oValid, bus.oData, bus.oSrc} !== {1'b1, 8'hA5, 2'd2})
      $display("FAIL single_capture: got valid=%b data=%h src=%0d want 1 a5 2",
               bus.oValid, bus.oData, bus.oSrc);
    else n_pass++;
    do_ack();
    n_total++;
    if ({bus.oValid, bus.oBusy, bus.oGrant} !== '0)
      $display("FAIL single_ack: got valid=%b busy=%b grant=%b want 0 0 0000",
               bus.oValid, bus.oBusy, bus.oGrant);
    else n_pass++;
    bus.iReq = '0;
  endtask

  task automatic test_round_robin();
    int cyc; bit ok; bit quiet;
    do_reset();
    bus.iReq  = 4'b1111;
    bus.iData = 32'h44332211;
    for (int k = 0; k < N; k++) begin
      wait_valid(20, cyc, ok);
      n_total++;
      if (!ok || bus.oSrc !== SW'(k) || bus.oData !== DW'(8'h11 * (k + 1)))
        $display("FAIL rr_order_%0d: got ok=%b src=%0d data=%h want 1 %0d %h",
                 k, ok, bus.oSrc, bus.oData, k, 8'h11 * (k + 1));
      else n_pass++;
      do_ack();
    end
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.oValid || bus.oBusy) quiet = 1'b0;
    end
    n_total++;
    if (quiet !== 1'b1) $display("FAIL rr_disarmed: got activity=1 want activity=0");
    else n_pass++;
    bus.iReq[1] = 1'b0;
    @(negedge clk);
    bus.iReq[1] = 1'b1;
    wait_valid(20, cyc, ok);
    n_total++;
    if (!ok || bus.oSrc !== 2'd1 || bus.oData !== 8'h22)
      $display("FAIL rr_rearm: got ok=%b src=%0d data=%h want 1 1 22", ok, bus.oSrc, bus.oData);
    else n_pass++;
    do_ack();
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.oValid || bus.oBusy) quiet = 1'b0;
    end
    n_total++;
    if (quiet !== 1'b1) $display("FAIL rr_single_recapture: got activity=1 want activity=0");
    else n_pass++;
    bus.iReq = '0;
  endtask

  task automatic test_abort();
    int cyc; bit ok; bit quiet;
    do_reset();
    bus.iData = $urandom();
    bus.iReq  = 4'b1000;
    @(negedge clk);
    n_total++;
    if (bus.oGrant !== 4'b1000) $display("FAIL abort_grant: got %b want 1000", bus.oGrant);
    else n_pass++;
    bus.iReq = 4'b0000;
    @(negedge clk);
    n_total++;
    if ({bus.oGrant, bus.oBusy} !== 5'b0)
      $display("FAIL abort_release: got grant=%b busy=%b want 0000 0", bus.oGrant, bus.oBusy);
    else n_pass++;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.oValid) quiet = 1'b0;
    end
    n_total++;
    if (quiet !== 1'b1) $display("FAIL abort_no_valid: got valid=1 want valid=0");
    else n_pass++;
    bus.iReq = 4'b1001;
    @(negedge clk);
    n_total++;
    if (bus.oGrant !== 4'b0001) $display("FAIL abort_ptr: got grant=%b want 0001", bus.oGrant);
    else n_pass++;
    wait_valid(20, cyc, ok);
    n_total++;
    if (!ok || bus.oSrc !== 2'd0) $display("FAIL abort_next: got ok=%b src=%0d want 1 0", ok, bus.oSrc);
    else n_pass++;
    do_ack();
    bus.iReq = '0;
  endtask

  task automatic test_hold_and_reset();
    int cyc; bit ok; bit stable;
    do_reset();
    bus.iData = {8'h00, 8'h00, 8'h00, 8'h3C};
    bus.iReq  = 4'b0001;
    wait_valid(20, cyc, ok);
    n_total++;
    if (!ok || bus.oData !== 8'h3C) $display("FAIL hold_capture: got ok=%b data=%h want 1 3c", ok, bus.oData);
    else n_pass++;
    stable = 1'b1;
    bus.iReq = 4'b0000;
    repeat (5) begin
      bus.iData = $urandom();
      @(negedge clk);
      if ({bus.oValid, bus.oData, bus.oSrc} !== {1'b1, 8'h3C, 2'd0}) stable = 1'b0;
    end
    n_total++;
    if (stable !== 1'b1)
      $display("FAIL hold_stable: got valid=%b data=%h src=%0d want 1 3c 0", bus.oValid, bus.oData, bus.oSrc);
    else n_pass++;
    do_ack();
    n_total++;
    if (bus.oValid !== 1'b0) $display("FAIL hold_ack: got valid=%b want 0", bus.oValid);
    else n_pass++;
    bus.iReq = 4'b0010;
    bus.iData = $urandom();
    @(negedge clk);
    n_total++;
    if (bus.oGrant !== 4'b0010) $display("FAIL hold_grant1: got %b want 0010", bus.oGrant);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({bus.oGrant, bus.oSrc, bus.oData, bus.oValid, bus.oBusy, dbg_state} !== '0)
      $display("FAIL reset_in_grant: got grant=%b src=%0d data=%h valid=%b busy=%b state=%0d want all 0",
               bus.oGrant, bus.oSrc, bus.oData, bus.oValid, bus.oBusy, dbg_state);
    else n_pass++;
    bus.iReq = '0;
  endtask

  // Transaction-level model: armed set + pointer, winner = first requesting
  // and armed index at or after the pointer, modulo N.
  task automatic test_random();
    bit armed[N];
    int ptr, win, cyc, d;
    bit ok, held, quiet;
    logic [N-1:0] mask;
    logic [SW+DW-1:0] got, exp;
    do_reset();
    for (int i = 0; i < N; i++) armed[i] = 1'b1;
    ptr = 0;
    for (int r = 0; r < 14; r++) begin
      mask = N'($urandom_range(0, 15));
      bus.iReq = mask;
      for (int i = 0; i < N; i++) if (!mask[i]) armed[i] = 1'b1;
      forever begin
        bus.iData = $urandom();
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && mask[(ptr + k) % N] && armed[(ptr + k) % N]) win = (ptr + k) % N;
        if (win < 0) begin
          quiet = 1'b1;
          repeat (6) begin
            @(negedge clk);
            if (bus.oValid || bus.oBusy) quiet = 1'b0;
          end
          n_total++;
          if (quiet !== 1'b1) $display("FAIL rand_idle_r%0d: got activity=1 want activity=0 mask=%b", r, mask);
          else n_pass++;
          break;
        end
        exp_q.push_back({SW'(win), bus.iData[win*DW +: DW]});
        wait_valid(HOLD + 10, cyc, ok);
        exp = exp_q.pop_front();
        n_total++;
        if (!ok || cyc != HOLD + 1)
          $display("FAIL rand_latency_r%0d: got ok=%b cycles=%0d want 1 %0d", r, ok, cyc, HOLD + 1);
        else n_pass++;
        if (!ok) break;
        got = {bus.oSrc, bus.oData};
        n_total++;
        if (got !== exp)
          $display("FAIL rand_data_r%0d: got src=%0d data=%h want src=%0d data=%h",
                   r, got[SW+DW-1:DW], got[DW-1:0], exp[SW+DW-1:DW], exp[DW-1:0]);
        else n_pass++;
        d = $urandom_range(0, 3);
        held = 1'b1;
        repeat (d) begin
          @(negedge clk);
          if (!bus.oValid || {bus.oSrc, bus.oData} !== exp) held = 1'b0;
        end
        n_total++;
        if (held !== 1'b1) $display("FAIL rand_hold_r%0d: got valid=%b want 1 held %0d cycles", r, bus.oValid, d);
        else n_pass++;
        do_ack();
        n_total++;
        if ({bus.oValid, bus.oBusy} !== 2'b00)
          $display("FAIL rand_ack_r%0d: got valid=%b busy=%b want 0 0", r, bus.oValid, bus.oBusy);
        else n_pass++;
        armed[win] = 1'b0;
        ptr = (win + 1) % N;
      end
    end
    bus.iReq = '0;
  endtask

`ifdef CAPTURE_ACK_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, hi; bit ok, early;
    do_reset();
    bus.iData = {8'h00, 8'hC3, 8'h00, 8'h5A};
    bus.iReq  = 4'b0001;
    wait_valid(20, cyc, ok);
    hi = 0; early = 1'b0;
    while (bus.oValid && hi < 200) begin
      hi++;
      if (bus.oTimeout) early = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (!ok || hi != ACKTO || early)
      $display("FAIL to_window: got ok=%b high=%0d early_pulse=%b want 1 %0d 0", ok, hi, early, ACKTO);
    else n_pass++;
    n_total++;
    if ({bus.oTimeout, bus.oGrant, bus.oData} !== {1'b1, 4'b0000, 8'h5A})
      $display("FAIL to_pulse: got timeout=%b grant=%b data=%h want 1 0000 5a", bus.oTimeout, bus.oGrant, bus.oData);
    else n_pass++;
    bus.iReq = 4'b0000;
    @(negedge clk);
    n_total++;
    if (bus.oTimeout !== 1'b0) $display("FAIL to_one_cycle: got %b want 0", bus.oTimeout);
    else n_pass++;
    bus.iReq = 4'b0101;
    wait_valid(20, cyc, ok);
    n_total++;
    if (!ok || bus.oSrc !== 2'd2) $display("FAIL to_ptr: got ok=%b src=%0d want 1 2", ok, bus.oSrc);
    else n_pass++;
    repeat (ACKTO - 1) @(negedge clk);
    n_total++;
    if (bus.oValid !== 1'b1) $display("FAIL to_last_cycle: got valid=%b want 1", bus.oValid);
    else n_pass++;
    do_ack();
    n_total++;
    if ({bus.oValid, bus.oTimeout} !== 2'b00)
      $display("FAIL to_ack_on_expiry: got valid=%b timeout=%b want 0 0", bus.oValid, bus.oTimeout);
    else n_pass++;
    bus.iReq = '0;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    bus.iReq = '0; bus.iData = '0; bus.iAck = 1'b0;
    test_reset();
    test_single_capture();
    test_round_robin();
    test_abort();
    test_hold_and_reset();
    test_random();
`ifdef CAPTURE_ACK_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
